dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: the pipeline MEM stage (port C)
//  and the debug/loader port (port D) that preloads and inspects data memory.
//  Fixed priority to C with starvation guard for D; drives the memory's address/write-enable/write-data
//  pins and returns registered read data plus a valid strobe to each requester.
// PARAMETERS
//  AW        8   address width (memory depth 2**AW)
//  DW        8   data width
//  MAX_WAIT  4   consecutive denied cycles of D before D is forced to win one access (1..15)
// PORTS
//  clk        in   1   system clock; all state on rising edge
//  rst        in   1   synchronous reset, active-high
//  c_req      in   1   port C request; held with c_addr/c_we/c_wdata stable until c_gnt
//  c_we       in   1   port C: 1 = write, 0 = read
//  c_addr     in   AW  port C address
//  c_wdata    in   DW  port C write data
//  c_gnt      out  1   port C granted this cycle (combinational)
//  c_rvalid   out  1   port C read data valid (one cycle after a granted read)
//  c_rdata    out  DW  port C registered read data
//  d_req/d_we/d_addr/d_wdata, d_gnt/d_rvalid/d_rdata  -- same meaning for port D
//  mem_addr   out  AW  to memory address
//  mem_wren   out  1   to memory write enable, ACTIVE-LOW (0 = write at next clk edge)
//  mem_wdata  out  DW  to memory write data
//  mem_rdata  in   DW  from memory, combinational read of mem_addr
// BEHAVIOUR
//  - Arbitration each cycle, combinational: force = (wait_cnt == MAX_WAIT).
//    d_gnt = d_req & (force | ~c_req); c_gnt = c_req & ~d_gnt. At most one grant per cycle.
//  - Mux: granted port's addr/wdata to mem_*; mem_wren = ~(granted port's we). No grant:
//    mem_addr = 0, mem_wdata = 0, mem_wren = 1 (no write). During rst: mem_wren = 1 regardless.
//  - Read latency 1: on granted read, x_rdata <= mem_rdata, x_rvalid <= 1 next cycle;
//    x_rvalid is a 1-cycle pulse; x_rdata holds last value otherwise. Granted write: no rvalid.
//  - Write completes at the clk edge ending the grant cycle; read in the following cycle sees it.
//  - wait_cnt (4b): rst -> 0; d_req & ~d_gnt -> +1 saturating at MAX_WAIT; d_gnt or ~d_req -> 0.
//  - FSM states (derived from wait_cnt): C_PRI (wait_cnt < MAX_WAIT), D_FORCE (== MAX_WAIT);
//    D_FORCE lasts exactly one cycle if d_req held, then C_PRI; d_req drop in D_FORCE -> C_PRI.
//  - Reset values: c_rvalid=d_rvalid=0, c_rdata=d_rdata=0, wait_cnt=0; c_gnt/d_gnt=0 while rst.
//  - Reset mid-access: request in the rst cycle is not granted and not written; rvalid cleared
//    even if a read was granted the cycle before.
//  - Same address, C write and D read pending: C wins (unless force); D read issued later sees new data.
//  - Requester dropping req before gnt: legal, request discarded, no side effect.
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined: adds out ports c_cnt[15:0], d_cnt[15:0], stall_cnt[15:0];
//   c_cnt/d_cnt +1 per grant of that port, stall_cnt +1 per cycle with any req denied;
//   all saturate at 16'hFFFF, reset to 0.
//  Not defined: ports and counters absent; arbitration identical.
// STRUCTURE
//  Package dmem_arb_pkg: port-id enum {PORT_NONE, PORT_C, PORT_D}, arbiter state enum
//   {C_PRI, D_FORCE}, WAIT_W = 4 constant, MEM_WREN_WRITE = 1'b0 / MEM_WREN_IDLE = 1'b1.
//  Sub-module dmem_arb_starve: wait_cnt + force output; everything else in dmem_arbiter.
// TESTING
//  1 rst=1 with c_req write 0x85<-0x15 -> no grant, mem_wren=1; after rst read 0x85 returns old value.
//  2 C write addr 0x85 data 0x15, next cycle C read 0x85 -> c_gnt both cycles, c_rvalid pulse, c_rdata=0x15.
//  3 C and D request every cycle, MAX_WAIT=4 -> grant pattern C,C,C,C,D repeating; wait_cnt 0..4.
//  4 D alone reads 0x90 after preload 0xDB -> d_gnt same cycle, d_rvalid next cycle, d_rdata=0xDB; c_rvalid=0.
//  5 D drops req in D_FORCE cycle -> c_gnt=1, wait_cnt=0, no D access, no memory write.
//  6 PERF_EN: 10 C grants + 2 D grants + 8 denied cycles -> c_cnt=10, d_cnt=2, stall_cnt=8.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional perf counters are enabled by defining DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        PORT_NONE,
        PORT_C,
        PORT_D
    } port_id_e;

    typedef enum logic {
        C_PRI,
        D_FORCE
    } arb_state_e;

    localparam int   WAIT_W         = 4;
    localparam logic MEM_WREN_WRITE = 1'b0;
    localparam logic MEM_WREN_IDLE  = 1'b1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation guard for port D: counts consecutive denied D cycles and
// raises force_win for exactly the cycle in which D must be served.
module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_req,
    input  logic d_gnt,
    output logic force_win
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    arb_state_e        state;

    // state mirrors (wait_cnt == MAX_WAIT) so force_win comes from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            state    <= C_PRI;
        end else if (d_req && !d_gnt) begin
            if (state != D_FORCE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            state <= (wait_cnt >= LAST) ? D_FORCE : C_PRI;
        end else begin
            wait_cnt <= '0;
            state    <= C_PRI;
        end
    end

    assign force_win = (state == D_FORCE);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline port C has priority, debug port D
// is guarded against starvation. DMEM_ARB_PERF_EN adds grant/stall counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wren,
    output logic [DW-1:0] mem_wdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]   c_cnt,
    output logic [15:0]   d_cnt,
    output logic [15:0]   stall_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);

    logic     force_win;
    port_id_e sel;

    dmem_arb_starve #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .d_req    (d_req),
        .d_gnt    (d_gnt),
        .force_win(force_win)
    );

    assign d_gnt = ~rst & d_req & (force_win | ~c_req);
    assign c_gnt = ~rst & c_req & ~d_gnt;

    always_comb begin
        sel = PORT_NONE;
        if (d_gnt) begin
            sel = PORT_D;
        end else if (c_gnt) begin
            sel = PORT_C;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = MEM_WREN_IDLE;
        unique case (sel)
            PORT_C: begin
                mem_addr  = c_addr;
                mem_wdata = c_wdata;
                mem_wren  = c_we ? MEM_WREN_WRITE : MEM_WREN_IDLE;
            end
            PORT_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wren  = d_we ? MEM_WREN_WRITE : MEM_WREN_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            d_rvalid <= d_gnt & ~d_we;
            if (c_gnt && !c_we) begin
                c_rdata <= mem_rdata;
            end
            if (d_gnt && !d_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic stall;

    assign stall = (c_req & ~c_gnt) | (d_req & ~d_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_cnt     <= '0;
            d_cnt     <= '0;
            stall_cnt <= '0;
        end else begin
            c_cnt     <= sat_inc(c_cnt, c_gnt);
            d_cnt     <= sat_inc(d_cnt, d_gnt);
            stall_cnt <= sat_inc(stall_cnt, stall);
        end
    end
`endif

endmodule
